uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 22 ++
 rtl/uart_rx.sv | 117 +++++++++++
 tb/tb_uart_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; resets to the line idle level (1).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualification, LSB-first data capture,
// stop-bit check with break handling, and a ready/overrun handshake to the consumer.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  logic                 rx_s;
  uart_rx_state_t       state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Frame FSM with counters and registered outputs; a completing byte overrides a same-cycle acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      data_out  <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rdy_clr) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end
      if (rx_en) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
          DATA: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              bit_cnt  <= bit_cnt + BIT_ONE;
              if (bit_cnt == BIT_LAST) begin
                state <= STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
          STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (rx_s) begin
                data_out <= shreg;
                rdy      <= 1'b1;
                overrun  <= rdy_clr ? overrun : (overrun | rdy);
                state    <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
          BREAK: begin
            // A held-low line must not be mistaken for a new start bit
            if (rx_s) begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: rx_en every 27 clk, 16x oversampling, 8N1 frames.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int TICK_CLKS = 27;
  localparam int BIT_CLKS  = TICK_CLKS * 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_en = 1'b0;
  logic       rx = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] data_out;
  logic       rdy;
  logic       frame_err;
  logic       overrun;

  int vectors = 0;
  int miscompares = 0;
  int fe_pulses = 0;
  int en_cnt = 0;

  uart_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_en     (rx_en),
    .rx        (rx),
    .rdy_clr   (rdy_clr),
    .data_out  (data_out),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (en_cnt == TICK_CLKS - 1) en_cnt = 0;
    else en_cnt = en_cnt + 1;
    rx_en = (en_cnt == 0);
  end

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_pulses = fe_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves rx at the stop-bit level when done
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BIT_CLKS);
    end
    rx = stop_bit;
    wait_clks(BIT_CLKS);
  endtask

  task automatic pulse_clr();
    rdy_clr = 1'b1;
    wait_clks(1);
    rdy_clr = 1'b0;
    wait_clks(1);
  endtask

  initial begin
    int fe_base;
    int n;
    int k;

    // Reset state
    wait_clks(5);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_rdy", 32'(rdy), 32'h0);
    check("rst_fe", 32'(frame_err), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    wait_clks(50);

    // Clean 0xA5, no acknowledge
    send_frame(8'hA5, 1'b1);
    check("a5_data", 32'(data_out), 32'hA5);
    check("a5_rdy", 32'(rdy), 32'h1);
    check("a5_ovr", 32'(overrun), 32'h0);
    check("a5_fe_cnt", 32'(fe_pulses), 32'h0);
    wait_clks(BIT_CLKS);

    // Start-bit glitch of about 4 ticks
    rx = 1'b0;
    wait_clks(4 * TICK_CLKS);
    rx = 1'b1;
    wait_clks(20 * TICK_CLKS);
    check("glitch_state", 32'(dut.state), 32'(IDLE));
    check("glitch_rdy", 32'(rdy), 32'h1);
    check("glitch_data", 32'(data_out), 32'hA5);
    check("glitch_fe_cnt", 32'(fe_pulses), 32'h0);

    pulse_clr();
    check("clr_rdy", 32'(rdy), 32'h0);

    // Framing error followed by a held-low line, then recovery with 0x81
    fe_base = fe_pulses;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    wait_clks(3 * BIT_CLKS);
    check("brk_state", 32'(dut.state), 32'(BREAK));
    check("brk_fe_once", 32'(fe_pulses - fe_base), 32'h1);
    check("brk_rdy", 32'(rdy), 32'h0);
    check("brk_data", 32'(data_out), 32'hA5);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("brk_exit_state", 32'(dut.state), 32'(IDLE));
    check("brk_exit_rdy", 32'(rdy), 32'h0);
    send_frame(8'h81, 1'b1);
    check("r81_data", 32'(data_out), 32'h81);
    check("r81_rdy", 32'(rdy), 32'h1);
    check("r81_fe_total", 32'(fe_pulses - fe_base), 32'h1);
    pulse_clr();

    // Back-to-back bytes without acknowledge
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("b2b_data", 32'(data_out), 32'h22);
    check("b2b_rdy", 32'(rdy), 32'h1);
    check("b2b_ovr", 32'(overrun), 32'h1);
    pulse_clr();
    check("b2b_clr_rdy", 32'(rdy), 32'h0);
    check("b2b_clr_ovr", 32'(overrun), 32'h0);
    wait_clks(BIT_CLKS);

    // Reset during data bit 4 of 0xFF
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    rx = 1'b1;
    wait_clks(4 * BIT_CLKS + 200);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(data_out), 32'h0);
    check("mid_rst_rdy", 32'(rdy), 32'h0);
    wait_clks(5);
    check("mid_rst_ovr", 32'(overrun), 32'h0);
    check("mid_rst_fe", 32'(frame_err), 32'h0);
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;
    wait_clks(5 * BIT_CLKS);
    check("post_rst_rdy", 32'(rdy), 32'h0);
    check("post_rst_data", 32'(data_out), 32'h0);
    send_frame(8'h5A, 1'b1);
    check("r5a_data", 32'(data_out), 32'h5A);
    check("r5a_rdy", 32'(rdy), 32'h1);
    check("r5a_ovr", 32'(overrun), 32'h0);
    wait_clks(BIT_CLKS);

    // Acknowledge in the exact completion cycle of 0xC3 while rdy is already 1
    n = 0;
    k = 0;
    fork
      send_frame(8'hC3, 1'b1);
      begin
        while (dut.state !== STOP && n < 12 * BIT_CLKS) begin
          @(negedge clk);
          #1;
          n++;
        end
        check("c3_reach_stop", 32'(dut.state), 32'(STOP));
        while (k < 16 && n < 14 * BIT_CLKS) begin
          @(negedge clk);
          #1;
          n++;
          if (rx_en) k++;
        end
        rdy_clr = 1'b1;
        @(negedge clk);
        rdy_clr = 1'b0;
      end
    join
    check("c3_ticks", 32'(k), 32'd16);
    check("c3_rdy", 32'(rdy), 32'h1);
    check("c3_data", 32'(data_out), 32'hC3);
    check("c3_ovr", 32'(overrun), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
